crc_frame_ctrl: RTL and testbench

Byte-stream sequencer for the bit-serial CRC engine (`crc_calc`). It accepts message bytes over a valid/ready stream and holds the engine in reset between frames. It serializes each byte MSB-first into the engine, appends CRC_WIDTH augmentation zeros, waits out the engine's one-cycle output register, then presents the captured CRC on a valid/ready result port. It also detects input underrun, since the engine has no clock enable and shifts on every non-reset cycle.

---
 rtl/crc_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// Byte-stream sequencer for a bit-serial CRC engine: serializes bytes MSB-first,
// appends CRC_WIDTH zeros, and returns the captured CRC over a valid/ready port.
module crc_frame_ctrl #(
  parameter int CRC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CRC_WIDTH-1:0] cfg_init,
  input  logic [CRC_WIDTH-1:0] cfg_poly,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CRC_WIDTH-1:0] res_crc,
  output logic                 res_err,
  output logic                 busy,
  output logic                 eng_rst_n,
  output logic                 eng_data,
  output logic [CRC_WIDTH-1:0] eng_init,
  output logic [CRC_WIDTH-1:0] eng_poly,
  input  logic [CRC_WIDTH-1:0] eng_crc
);
  localparam int ZW = $clog2(CRC_WIDTH + 1);
  localparam logic [ZW-1:0] ZLAST = ZW'(CRC_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, AUG, DRAIN, CAPT} state_t;

  state_t               state_q, state_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [7:0]           hold_q, hold_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [ZW-1:0]        zcnt_q, zcnt_d;
  logic                 last_q, last_d;
  logic                 hold_full_q, hold_full_d;
  logic                 hold_last_q, hold_last_d;
  logic                 last_seen_q, last_seen_d;
  logic                 err_q, err_d;
  logic                 eng_rst_n_q, eng_rst_n_d;
  logic [CRC_WIDTH-1:0] eng_poly_q, eng_poly_d;
  logic                 res_valid_q, res_valid_d;
  logic [CRC_WIDTH-1:0] res_crc_q, res_crc_d;
  logic                 res_err_q, res_err_d;
  logic                 accept;

  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:    s_ready = !res_valid_q || res_ready;
        SHIFT:   s_ready = !hold_full_q && !last_seen_q;
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign accept = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    bitcnt_d    = bitcnt_q;
    zcnt_d      = zcnt_q;
    last_d      = last_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    last_seen_d = last_seen_q;
    err_d       = err_q;
    eng_poly_d  = eng_poly_q;
    res_valid_d = res_valid_q;
    res_crc_d   = res_crc_q;
    res_err_d   = res_err_q;
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d     = s_data;
          last_d      = s_last;
          last_seen_d = s_last;
          hold_full_d = 1'b0;
          hold_last_d = 1'b0;
          err_d       = 1'b0;
          bitcnt_d    = 3'd0;
          eng_poly_d  = cfg_poly;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d  = {shreg_q[6:0], 1'b0};
        bitcnt_d = bitcnt_q + 3'd1;
        if (accept) last_seen_d = last_seen_q | s_last;
        // Byte boundary: the next byte must already be held or arrive right now.
        if (bitcnt_q == 3'd7) begin
          if (last_q) begin
            zcnt_d  = '0;
            state_d = AUG;
          end else if (hold_full_q) begin
            shreg_d     = hold_q;
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = s_data;
            last_d  = s_last;
          end else begin
            err_d   = 1'b1;
            state_d = CAPT;
          end
        end else if (accept) begin
          hold_d      = s_data;
          hold_last_d = s_last;
          hold_full_d = 1'b1;
        end
      end
      AUG: begin
        if (zcnt_q == ZLAST) state_d = DRAIN;
        else                 zcnt_d  = zcnt_q + ZW'(1);
      end
      DRAIN: state_d = CAPT;
      CAPT: begin
        res_valid_d = 1'b1;
        res_crc_d   = err_q ? '0 : eng_crc;
        res_err_d   = err_q;
        err_d       = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    eng_rst_n_d = (state_d == SHIFT) || (state_d == AUG) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      zcnt_q      <= '0;
      last_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
      eng_rst_n_q <= 1'b0;
      eng_poly_q  <= '0;
      res_valid_q <= 1'b0;
      res_crc_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      zcnt_q      <= zcnt_d;
      last_q      <= last_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
      eng_rst_n_q <= eng_rst_n_d;
      eng_poly_q  <= eng_poly_d;
      res_valid_q <= res_valid_d;
      res_crc_q   <= res_crc_d;
      res_err_q   <= res_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign eng_data  = (state_q == SHIFT) && shreg_q[7];
  assign eng_rst_n = eng_rst_n_q;
  assign eng_init  = cfg_init;
  assign eng_poly  = eng_poly_q;
  assign res_valid = res_valid_q;
  assign res_crc   = res_crc_q;
  assign res_err   = res_err_q;
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl at CRC_WIDTH 8 and 16, each attached to a
// behavioural bit-serial engine; sel picks which instance the stimulus drives.
module tb_crc_frame_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, rr = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic [31:0] cfg_init = 32'h0, cfg_poly = 32'h0;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       s_ready8, res_valid8, res_err8, busy8, eng_rst_n8, eng_data8;
  logic [7:0] res_crc8, eng_init8, eng_poly8, e8_crc, e8_r, e8_m;
  logic        s_ready16, res_valid16, res_err16, busy16, eng_rst_n16, eng_data16;
  logic [15:0] res_crc16, eng_init16, eng_poly16, e16_crc, e16_r, e16_m;

  crc_frame_ctrl #(.CRC_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_init(cfg_init[7:0]), .cfg_poly(cfg_poly[7:0]),
    .s_valid(s_valid & ~sel), .s_ready(s_ready8), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid8), .res_ready(rr & ~sel), .res_crc(res_crc8), .res_err(res_err8),
    .busy(busy8), .eng_rst_n(eng_rst_n8), .eng_data(eng_data8), .eng_init(eng_init8),
    .eng_poly(eng_poly8), .eng_crc(e8_crc));

  crc_frame_ctrl #(.CRC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_init(cfg_init[15:0]), .cfg_poly(cfg_poly[15:0]),
    .s_valid(s_valid & sel), .s_ready(s_ready16), .s_data(s_data), .s_last(s_last),
    .res_valid(res_valid16), .res_ready(rr & sel), .res_crc(res_crc16), .res_err(res_err16),
    .busy(busy16), .eng_rst_n(eng_rst_n16), .eng_data(eng_data16), .eng_init(eng_init16),
    .eng_poly(eng_poly16), .eng_crc(e16_crc));

  // Augmented-form engines; init is folded into the first CRC_WIDTH message bits.
  always @(posedge clk) begin
    e8_crc <= e8_r;
    if (!eng_rst_n8) begin
      e8_r <= '0;
      e8_m <= eng_init8;
    end else begin
      e8_r <= {e8_r[6:0], eng_data8 ^ e8_m[7]} ^ (e8_r[7] ? eng_poly8 : 8'h00);
      e8_m <= {e8_m[6:0], 1'b0};
    end
  end

  always @(posedge clk) begin
    e16_crc <= e16_r;
    if (!eng_rst_n16) begin
      e16_r <= '0;
      e16_m <= eng_init16;
    end else begin
      e16_r <= {e16_r[14:0], eng_data16 ^ e16_m[15]} ^ (e16_r[15] ? eng_poly16 : 16'h0000);
      e16_m <= {e16_m[14:0], 1'b0};
    end
  end

  logic        s_ready_m, res_valid_m, res_err_m, busy_m, eng_rst_n_m, eng_data_m;
  logic [31:0] res_crc_m, eng_poly_m;
  assign s_ready_m   = sel ? s_ready16   : s_ready8;
  assign res_valid_m = sel ? res_valid16 : res_valid8;
  assign res_err_m   = sel ? res_err16   : res_err8;
  assign busy_m      = sel ? busy16      : busy8;
  assign eng_rst_n_m = sel ? eng_rst_n16 : eng_rst_n8;
  assign eng_data_m  = sel ? eng_data16  : eng_data8;
  assign res_crc_m   = sel ? {16'h0, res_crc16}  : {24'h0, res_crc8};
  assign eng_poly_m  = sel ? {16'h0, eng_poly16} : {24'h0, eng_poly8};

  int n_total = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] crc; logic err; } exp_t;
  exp_t sb[$];
  logic [7:0] msg [0:15];

  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input int n);
    logic [31:0] c, mask;
    logic fb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    c = init & mask;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[w-1] ^ msg[i][b];
        c  = (c << 1) & mask;
        if (fb) c = c ^ poly;
      end
    return c;
  endfunction

  task automatic push(input logic [31:0] crc, input logic err);
    exp_t e;
    e.crc = crc;
    e.err = err;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && res_valid_m && rr) begin
      if (sb.size() == 0) chk("spurious_res", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("res_crc", res_crc_m, e.crc);
        chk("res_err", {31'h0, res_err_m}, {31'h0, e.err});
      end
    end
  end

  int acc_cyc = 0, acc_wait = 0;
  task automatic send(input int n, input logic mark_last);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      s_valid = 1'b1;
      s_data  = msg[i];
      s_last  = mark_last && (i == n - 1);
      @(negedge clk);
      while (!s_ready_m && t < 300) begin
        t++;
        @(negedge clk);
      end
      if (t >= 300) chk("accept_timeout", t, 0);
      if (i == 0) acc_wait = t;
      @(posedge clk); #1;
      if (i == 0) acc_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    int k;
    k = 0;
    while (!res_valid_m && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (!res_valid_m) chk("res_timeout", 32'd0, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic load_ascii();
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    int lat, n;
    logic [31:0] held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'h0, s_ready8}, 32'd0);
    #1;
    chk("rst_busy", {30'h0, busy8, busy16}, 32'd0);
    chk("rst_res", {29'h0, res_valid8, res_err8, res_valid16}, 32'd0);
    chk("rst_res_crc", res_crc_m, 32'd0);
    chk("rst_eng", {30'h0, eng_rst_n8, eng_data8}, 32'd0);
    chk("rst_eng_poly", eng_poly_m, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte, exact latency
    sel = 1'b0; cfg_poly = 32'h07; cfg_init = 32'h00;
    msg[0] = 8'h01; push(32'h07, 1'b0);
    send(1, 1'b1);
    wait_res(lat);
    chk("lat_1byte", lat, 32'd18);
    repeat (2) @(posedge clk); #1;

    // "123456789" streamed back-to-back
    load_ascii(); push(32'hF4, 1'b0);
    send(9, 1'b1);
    wait_res(lat);
    chk("lat_9byte", lat, 32'd82);
    repeat (2) @(posedge clk); #1;

    // 16-bit engine, init 0 then FFFF with result held
    sel = 1'b1; cfg_poly = 32'h1021; cfg_init = 32'h0000;
    push(32'h31C3, 1'b0);
    send(9, 1'b1);
    wait_res(lat);
    chk("lat_w16", lat, 32'd90);
    repeat (2) @(posedge clk); #1;
    cfg_init = 32'hFFFF; rr = 1'b0;
    push(32'h29B1, 1'b0);
    send(9, 1'b1);
    wait_res(lat);
    held = res_crc_m;
    s_valid = 1'b1; s_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, res_valid_m}, 32'd1);
      chk("hold_crc", res_crc_m, held);
      chk("hold_s_ready", {31'h0, s_ready_m}, 32'd0);
    end
    s_valid = 1'b0; rr = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Underrun: one byte without last, then nothing
    sel = 1'b0; cfg_poly = 32'h07; cfg_init = 32'h00;
    msg[0] = 8'hC3; push(32'h0, 1'b1);
    send(1, 1'b0);
    wait_res(lat);
    chk("lat_underrun", lat, 32'd9);
    chk("underrun_eng_rst", {31'h0, eng_rst_n_m}, 32'd0);
    repeat (12) @(posedge clk); #1;
    msg[0] = 8'h01; push(32'h07, 1'b0);
    send(1, 1'b1);
    wait_res(lat);
    repeat (2) @(posedge clk); #1;

    // Reset pulse during augmentation
    msg[0] = 8'h01; push(32'h07, 1'b0);
    send(1, 1'b1);
    repeat (10) @(posedge clk); #1;
    chk("in_aug_busy", {31'h0, busy_m}, 32'd1);
    rst_n = 1'b0; sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'h0, busy_m}, 32'd0);
    chk("abort_eng_rst", {31'h0, eng_rst_n_m}, 32'd0);
    chk("abort_res_valid", {31'h0, res_valid_m}, 32'd0);
    chk("abort_eng_data", {31'h0, eng_data_m}, 32'd0);
    repeat (30) @(posedge clk); #1;
    msg[0] = 8'hA5; msg[1] = 8'h3C;
    push(ref_crc(8, 32'h07, 32'h00, 2), 1'b0);
    send(2, 1'b1);
    wait_res(lat);
    repeat (2) @(posedge clk); #1;

    // Pending result consumed on the same edge as the next accept
    rr = 1'b0; cfg_init = 32'h5A;
    msg[0] = 8'h5A; push(ref_crc(8, 32'h07, 32'h5A, 1), 1'b0);
    send(1, 1'b1);
    wait_res(lat);
    @(posedge clk); #1;
    msg[0] = 8'h12; msg[1] = 8'hEF; msg[2] = 8'h80;
    push(ref_crc(8, 32'h07, 32'h5A, 3), 1'b0);
    rr = 1'b1;
    send(3, 1'b1);
    chk("same_edge_accept", acc_wait, 32'd0);
    wait_res(lat);
    repeat (2) @(posedge clk); #1;

    // Randomised frames on both widths
    for (int f = 0; f < 6; f++) begin
      sel = f[0];
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      cfg_init = sel ? {16'h0, 16'($urandom)} : {24'h0, 8'($urandom)};
      cfg_poly = sel ? {16'h0, 16'($urandom) | 16'h1} : {24'h0, 8'($urandom) | 8'h1};
      push(ref_crc(sel ? 16 : 8, cfg_poly, cfg_init, n), 1'b0);
      send(n, 1'b1);
      wait_res(lat);
      chk("lat_rand", lat, 8 * n + (sel ? 16 : 8) + 2);
      repeat (2) @(posedge clk); #1;
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
